// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage and PC register of the single-cycle LEGv8 datapath.
// The unit holds the PC and fetches one 32-bit instruction at a time over a
// req/ack handshake, so instruction memory may insert any number of wait
// states. The instruction it captures is held for the decoder and sign
// extender, and the sign-extended immediate it gets back (BusImm) is used to
// form B / CBZ targets.
//
// Ports
//   CLK           in   1   clock, rising edge
//   Reset         in   1   synchronous, active-high
//   ImemReq       out  1   fetch request to instruction memory
//   ImemAddr      out  64  fetch address (same as CurrentPC)
//   ImemAck       in   1   instruction memory data valid this cycle
//   ImemData      in   32  instruction word, taken when ImemReq & ImemAck
//   Instruction   out  32  held instruction for decoder / sign extender
//   InstrValid    out  1   Instruction is stable and executes this cycle
//   CurrentPC     out  64  PC of Instruction
//   BusImm        in   64  sign-extended word offset for B / CBZ
//   Uncondbranch  in   1   B: always taken
//   Branch        in   1   CBZ: taken when Zero
//   Zero          in   1   ALU zero flag
//   Stall         in   1   datapath not ready to retire this instruction
//   InstrCount    out  32  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [63:0] CurrentPC,
    input  logic [63:0] BusImm,
    input  logic        Uncondbranch,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Stall,
    output logic [31:0] InstrCount
);

    // The PC is always word aligned, whatever the parameter says.
    localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic        r_imemReq;
    logic        r_instrValid;
    logic [31:0] r_instrCount;

    logic        w_taken;
    logic [63:0] w_branchOffset;
    logic [63:0] w_nextPc;

    // BusImm is a word offset; shifting left by two drops its top two bits
    // and turns it into a byte offset. All additions wrap mod 2^64, so a
    // negative offset simply branches backward.
    assign w_taken        = Uncondbranch | (Branch & Zero);
    assign w_branchOffset = BusImm << 2;
    assign w_nextPc       = w_taken ? (r_pc + w_branchOffset) : (r_pc + 64'd4);

    // Fetch FSM. ImemReq and InstrValid are registered alongside the state
    // so they are true flop outputs. ImemAck is only looked at in REQ, so an
    // early or late ack (including one arriving right after a reset) never
    // captures anything. In EXEC the PC and instruction are frozen until the
    // datapath drops Stall; only then does the PC advance and the retire
    // counter tick.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC_ALIGNED;
            r_instr      <= 32'h0;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b0;
            r_instrCount <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state   <= ST_REQ;
                    r_imemReq <= 1'b1;
                end
                ST_REQ: begin
                    if (ImemAck) begin
                        r_instr      <= ImemData;
                        r_state      <= ST_EXEC;
                        r_imemReq    <= 1'b0;
                        r_instrValid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!Stall) begin
                        r_pc         <= w_nextPc;
                        r_instrCount <= r_instrCount + 32'd1;
                        r_state      <= ST_REQ;
                        r_imemReq    <= 1'b1;
                        r_instrValid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_imemReq    <= 1'b0;
                    r_instrValid <= 1'b0;
                end
            endcase
        end
    end

    assign ImemReq     = r_imemReq;
    assign ImemAddr    = r_pc;
    assign CurrentPC   = r_pc;
    assign Instruction = r_instr;
    assign InstrValid  = r_instrValid;
    assign InstrCount  = r_instrCount;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. A table of fetch records (address,
// memory wait, instruction word, branch controls, stall length, expected next
// PC) is walked in order; each captured instruction is pushed to a scoreboard
// queue when the ack is driven and popped when the unit presents it in EXEC.
// Hand-written sequences cover reset during REQ and during EXEC.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [63:0] TB_RESET_PC = 64'h0000_0000_0000_0103;
    localparam logic [63:0] PC_AFTER_RESET = 64'h0000_0000_0000_0100;

    logic        CLK;
    logic        Reset;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [63:0] CurrentPC;
    logic [63:0] BusImm;
    logic        Uncondbranch;
    logic        Branch;
    logic        Zero;
    logic        Stall;
    logic [31:0] InstrCount;

    instr_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemAck      (ImemAck),
        .ImemData     (ImemData),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .CurrentPC    (CurrentPC),
        .BusImm       (BusImm),
        .Uncondbranch (Uncondbranch),
        .Branch       (Branch),
        .Zero         (Zero),
        .Stall        (Stall),
        .InstrCount   (InstrCount)
    );

    typedef struct {
        logic [63:0] pc;
        int          ackDelay;
        logic [31:0] data;
        logic        uncond;
        logic        branch;
        logic        zero;
        logic [63:0] busImm;
        int          stallCycles;
        logic [63:0] nextPc;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } exp_t;

    vec_t        vecs[14];
    exp_t        expQ[$];
    int          nCompared;
    int          nMismatch;
    logic [31:0] expCount;

    // Free-running clock, 10 time units per cycle.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one clock and settle just after the edge, away from it.
    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    // Single comparison: counts it and reports a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".ImemReq"}, {63'h0, ImemReq}, 64'h0);
        checkOutput({tag, ".InstrValid"}, {63'h0, InstrValid}, 64'h0);
        checkOutput({tag, ".Instruction"}, {32'h0, Instruction}, 64'h0);
        checkOutput({tag, ".InstrCount"}, {32'h0, InstrCount}, 64'h0);
        checkOutput({tag, ".CurrentPC"}, CurrentPC, PC_AFTER_RESET);
    endtask

    // Runs one table record: waits for the request, inserts the memory wait
    // states, acks with the instruction word, then checks EXEC (including any
    // stall cycles) and the address of the following request.
    task automatic applyStimulus(input int idx);
        vec_t v;
        exp_t e;
        int   waited;
        v = vecs[idx];
        waited = 0;
        while (ImemReq !== 1'b1 && waited < 20) begin
            stepCycle();
            waited++;
        end
        if (ImemReq !== 1'b1) begin
            checkOutput($sformatf("v%0d.reqTimeout", idx), {63'h0, ImemReq}, 64'h1);
            return;
        end
        checkOutput($sformatf("v%0d.ImemAddr", idx), ImemAddr, v.pc);
        checkOutput($sformatf("v%0d.reqValid", idx), {63'h0, InstrValid}, 64'h0);

        for (int d = 0; d < v.ackDelay; d++) begin
            ImemAck      = 1'b0;
            ImemData     = $urandom;
            Uncondbranch = 1'($urandom);
            Branch       = 1'($urandom);
            Zero         = 1'($urandom);
            BusImm       = {$urandom, $urandom};
            stepCycle();
            checkOutput($sformatf("v%0d.waitReq%0d", idx, d), {63'h0, ImemReq}, 64'h1);
            checkOutput($sformatf("v%0d.waitAddr%0d", idx, d), ImemAddr, v.pc);
            checkOutput($sformatf("v%0d.waitValid%0d", idx, d), {63'h0, InstrValid}, 64'h0);
        end

        ImemAck  = 1'b1;
        ImemData = v.data;
        e.pc     = v.pc;
        e.data   = v.data;
        expQ.push_back(e);
        stepCycle();

        // EXEC: keep ack high with a different word to prove no recapture.
        ImemAck      = 1'b1;
        ImemData     = ~v.data;
        Uncondbranch = v.uncond;
        Branch       = v.branch;
        Zero         = v.zero;
        BusImm       = v.busImm;
        if (expQ.size() == 0) begin
            checkOutput($sformatf("v%0d.scoreboard", idx), 64'h0, 64'h1);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("v%0d.Instruction", idx), {32'h0, Instruction}, {32'h0, e.data});
            checkOutput($sformatf("v%0d.CurrentPC", idx), CurrentPC, e.pc);
        end
        checkOutput($sformatf("v%0d.execValid", idx), {63'h0, InstrValid}, 64'h1);
        checkOutput($sformatf("v%0d.execReq", idx), {63'h0, ImemReq}, 64'h0);
        checkOutput($sformatf("v%0d.execCount", idx), {32'h0, InstrCount}, {32'h0, expCount});

        for (int s = 0; s < v.stallCycles; s++) begin
            Stall = 1'b1;
            stepCycle();
            checkOutput($sformatf("v%0d.stallInstr%0d", idx, s), {32'h0, Instruction}, {32'h0, v.data});
            checkOutput($sformatf("v%0d.stallPC%0d", idx, s), CurrentPC, v.pc);
            checkOutput($sformatf("v%0d.stallValid%0d", idx, s), {63'h0, InstrValid}, 64'h1);
            checkOutput($sformatf("v%0d.stallReq%0d", idx, s), {63'h0, ImemReq}, 64'h0);
            checkOutput($sformatf("v%0d.stallCount%0d", idx, s), {32'h0, InstrCount}, {32'h0, expCount});
        end

        Stall = 1'b0;
        stepCycle();
        expCount = expCount + 32'd1;
        checkOutput($sformatf("v%0d.retireCount", idx), {32'h0, InstrCount}, {32'h0, expCount});
        checkOutput($sformatf("v%0d.nextReq", idx), {63'h0, ImemReq}, 64'h1);
        checkOutput($sformatf("v%0d.nextAddr", idx), ImemAddr, v.nextPc);
        checkOutput($sformatf("v%0d.nextValid", idx), {63'h0, InstrValid}, 64'h0);

        // Branch controls are don't-care outside EXEC.
        ImemAck      = 1'b0;
        Uncondbranch = 1'($urandom);
        Branch       = 1'($urandom);
        Zero         = 1'($urandom);
        BusImm       = {$urandom, $urandom};
    endtask

    initial begin
        nCompared = 0;
        nMismatch = 0;
        expCount  = 32'd0;

        // pc, ackDelay, data, uncond, branch, zero, busImm, stall, nextPc
        vecs[0]  = '{64'h100, 0, 32'h9100_0421, 1'b0, 1'b0, 1'b0, 64'h0, 0, 64'h104};
        vecs[1]  = '{64'h104, 0, 32'h9100_0421, 1'b0, 1'b0, 1'b0, 64'h0, 0, 64'h108};
        vecs[2]  = '{64'h108, 0, 32'h9100_0421, 1'b0, 1'b0, 1'b0, 64'h0, 0, 64'h10C};
        vecs[3]  = '{64'h10C, 3, 32'h1400_0000, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC1, 0, 64'h10};
        vecs[4]  = '{64'h10,  0, 32'h17FF_FFFF, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0C};
        vecs[5]  = '{64'h0C,  0, 32'h1400_0005, 1'b1, 1'b0, 1'b1, 64'h5, 0, 64'h20};
        vecs[6]  = '{64'h20,  0, 32'hB400_0100, 1'b0, 1'b1, 1'b0, 64'h8, 0, 64'h24};
        vecs[7]  = '{64'h24,  1, 32'h17FF_FFFF, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h20};
        vecs[8]  = '{64'h20,  0, 32'hB400_0100, 1'b0, 1'b1, 1'b1, 64'h8, 0, 64'h40};
        vecs[9]  = '{64'h40,  2, 32'hF840_0020, 1'b0, 1'b0, 1'b1, 64'h4000_0000_0000_0001, 2, 64'h44};
        vecs[10] = '{64'h44,  0, 32'h17FF_FFEE, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEE, 0, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h8B02_0020, 1'b0, 1'b0, 1'b0, 64'h7, 0, 64'h0};
        vecs[12] = '{64'h0,   1, 32'hCB02_0020, 1'b0, 1'b0, 1'b1, 64'h3, 1, 64'h4};
        vecs[13] = '{64'h100, 0, 32'h9100_0421, 1'b0, 1'b0, 1'b0, 64'h0, 0, 64'h104};

        Reset        = 1'b1;
        ImemAck      = 1'b0;
        ImemData     = 32'h0;
        BusImm       = 64'h0;
        Uncondbranch = 1'b0;
        Branch       = 1'b0;
        Zero         = 1'b0;
        Stall        = 1'b0;

        stepCycle();
        stepCycle();
        checkResetState("reset");

        // Ack tied high from the cycle after reset: the IDLE cycle must not
        // capture, and the unit must still take one cycle in IDLE.
        Reset    = 1'b0;
        ImemAck  = 1'b1;
        ImemData = 32'h9100_0421;
        checkOutput("idle.ImemReq", {63'h0, ImemReq}, 64'h0);
        stepCycle();
        checkOutput("firstReq.ImemReq", {63'h0, ImemReq}, 64'h1);
        checkOutput("firstReq.Instruction", {32'h0, Instruction}, 64'h0);
        checkOutput("firstReq.ImemAddr", ImemAddr, PC_AFTER_RESET);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(i);
        end

        // Reset in the middle of a memory wait; the ack that follows lands in
        // IDLE and must be dropped, and fetching restarts at the reset PC.
        ImemAck = 1'b0;
        stepCycle();
        checkOutput("midReq.ImemReq", {63'h0, ImemReq}, 64'h1);
        Reset = 1'b1;
        stepCycle();
        checkResetState("resetInReq");
        Reset    = 1'b0;
        ImemAck  = 1'b1;
        ImemData = 32'hDEAD_BEEF;
        stepCycle();
        checkOutput("lateAck.ImemReq", {63'h0, ImemReq}, 64'h1);
        checkOutput("lateAck.Instruction", {32'h0, Instruction}, 64'h0);
        checkOutput("lateAck.InstrValid", {63'h0, InstrValid}, 64'h0);
        checkOutput("lateAck.ImemAddr", ImemAddr, PC_AFTER_RESET);
        ImemAck  = 1'b0;
        expCount = 32'd0;

        applyStimulus(13);

        // Reset during EXEC takes priority over retiring the instruction.
        ImemAck  = 1'b1;
        ImemData = 32'h1234_5678;
        stepCycle();
        checkOutput("execB.Instruction", {32'h0, Instruction}, 64'h1234_5678);
        checkOutput("execB.CurrentPC", CurrentPC, 64'h104);
        checkOutput("execB.InstrValid", {63'h0, InstrValid}, 64'h1);
        ImemAck = 1'b0;
        Stall   = 1'b0;
        Reset   = 1'b1;
        stepCycle();
        checkResetState("resetInExec");
        Reset = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("restart.ImemAddr", ImemAddr, PC_AFTER_RESET);
        checkOutput("restart.ImemReq", {63'h0, ImemReq}, 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
